// File: rtl/timebase_pkg.sv
// Purpose: shared types and constants for the seconds/minutes timebase front end.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package timebase_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    REPEAT   = 2'd2
  } adv_state_t;

  localparam int CLK_HZ_DEFAULT = 100_000_000;
  localparam int DB_MS_DEFAULT  = 10;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timebase_adv_debounce.sv
// Purpose: two-flop synchronizer plus counter debounce for one raw pushbutton.
// Latency: dout follows a steady din change DB_CYCLES+2 clocks after din is first sampled.
// Backpressure: none; level output, always valid.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   din  - raw asynchronous button level
//   dout - synchronized, debounced level
module debounce
  import timebase_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_w(DB_CYCLES);

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("debounce: DB_CYCLES must be >= 1");
  end

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Any cycle where the synchronized level agrees with the debounced
    // level restarts the count, so short glitches never accumulate.
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/timebase_adv.sv
// Purpose: 1 Hz enb tick divider plus debounced, auto-repeating advance-minute pulse.
// Latency: first adv_min DB_CYCLES+3 clocks after press is sampled; enb every TICK_DIV clocks.
// Backpressure: none; both outputs are free-running single-cycle pulses.
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   btn_adv - raw asynchronous advance pushbutton, active-high
//   enb     - one-cycle timebase tick for the seconds stage
//   adv_min - one-cycle advance pulse (first press, then auto-repeat)
module timebase_adv
  import timebase_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DB_CYCLES  = 1_000_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_adv,
  output logic enb,
  output logic adv_min
);

  localparam int TW      = $clog2(TICK_DIV);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = cnt_w(RPT_MAX);

  if (TICK_DIV < 2) begin : g_bad_tick
    $error("timebase_adv: TICK_DIV must be >= 2");
  end
  if (RPT_DELAY < 2) begin : g_bad_dly
    $error("timebase_adv: RPT_DELAY must be >= 2");
  end
  if (RPT_PERIOD < 2) begin : g_bad_per
    $error("timebase_adv: RPT_PERIOD must be >= 2");
  end

  logic          btn_db;
  logic [TW-1:0] tick_q, tick_d;
  logic          enb_q, enb_d;
  adv_state_t    state_q, state_d;
  logic [RW-1:0] tmr_q, tmr_d;
  logic          adv_q, adv_d;

  debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn_adv),
    .dout(btn_db)
  );

  // Tick divider: enb is registered off the wrap so it is glitch-free.
  always_comb begin
    enb_d  = (tick_q == TW'(TICK_DIV - 1));
    tick_d = enb_d ? '0 : tick_q + TW'(1);
  end

  // Advance FSM. IDLE is only ever entered with btn_db low, so btn_db high
  // while in IDLE is the debounced rising edge. Release is checked before
  // the timer so a release never produces a final pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    adv_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_db) begin
          adv_d   = 1'b1;
          tmr_d   = RW'(RPT_DELAY - 1);
          state_d = HOLD_DLY;
        end
      end
      HOLD_DLY, REPEAT: begin
        if (!btn_db) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          adv_d   = 1'b1;
          tmr_d   = RW'(RPT_PERIOD - 1);
          state_d = REPEAT;
        end else begin
          tmr_d = tmr_q - RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      enb_q   <= 1'b0;
      state_q <= IDLE;
      tmr_q   <= '0;
      adv_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      enb_q   <= enb_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      adv_q   <= adv_d;
    end
  end

  assign enb     = enb_q;
  assign adv_min = adv_q;

endmodule
